// File: rtl/viterbi_pkg.sv
// Shared constants, types and trellis helpers for the K=8, rate-1/2 Viterbi decoder.
// Generators: G1 = 8'b11111001 (n1), G2 = 8'b10100111 (n2).
// Trellis state holds the newest 7 message bits, newest in the MSB.
package viterbi_pkg;

  localparam int K       = 8;
  localparam int NSTATES = 2 ** (K - 1);

  localparam logic [K-1:0] GEN1 = 8'b11111001;
  localparam logic [K-1:0] GEN2 = 8'b10100111;

  typedef logic [K-2:0] state_t;

  typedef enum logic [1:0] {
    RECV,
    TRACE,
    OUT
  } fsm_t;

  // Encoder output {n1, n2} on the branch entering 'state' from predecessor
  // {state[5:0], b}: the full encoder register is {state, b}.
  function automatic logic [1:0] expected_sym(state_t state, logic b);
    logic [K-1:0] r;
    r = {state, b};
    return {^(GEN1 & r), ^(GEN2 & r)};
  endfunction

  // Hamming distance between two hard-decision symbol pairs (0..2).
  function automatic logic [1:0] hamming2(logic [1:0] a, logic [1:0] b);
    logic [1:0] e;
    e = a ^ b;
    return {1'b0, e[1]} + {1'b0, e[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// One add-compare-select cell: picks the cheaper of two incoming paths.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: pm0/pm1 predecessor metrics (x=0 / x=1), bm0/bm1 branch metrics,
//        pm_new selected metric, dec chosen predecessor bit (0 on ties).
module viterbi_acs #(
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  logic [PM_W:0]   s0, s1;
  logic [PM_W-1:0] c0, c1;

  assign s0 = {1'b0, pm0} + {{(PM_W - 1){1'b0}}, bm0};
  assign s1 = {1'b0, pm1} + {{(PM_W - 1){1'b0}}, bm1};

  // Saturate instead of wrapping so a bad path can never look cheap.
  assign c0 = s0[PM_W] ? {PM_W{1'b1}} : s0[PM_W-1:0];
  assign c1 = s1[PM_W] ? {PM_W{1'b1}} : s1[PM_W-1:0];

  // Strict compare: equal costs keep the x=0 predecessor.
  assign dec    = (c1 < c0);
  assign pm_new = dec ? c1 : c0;

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder (K=8, rate 1/2); one symbol per cycle, traceback at frame end.
// Latency: sym_last handshake to first msg_valid is L+1 cycles (L symbols in frame).
// Backpressure: sym_ready only in RECV; msg_* held steady while msg_ready is low.
// Ports: clk, n_reset (async active-low); sym_valid/sym_ready/n1/n2/sym_last symbol input;
//        msg_valid/msg_ready/msg_out/msg_last decoded bits; overflow sticky truncation flag.
// Build option ZERO_TAIL_EN: frames end with 8 flush symbols, traceback from state 0,
//        last 8 decoded bits dropped. Undefined: traceback from min-metric state, all bits out.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int MAX_SYMS = 64,
  parameter int PM_W     = 8
) (
  input  logic clk,
  input  logic n_reset,
  input  logic sym_valid,
  input  logic n1,
  input  logic n2,
  input  logic sym_last,
  output logic sym_ready,
  output logic msg_out,
  output logic msg_valid,
  input  logic msg_ready,
  output logic msg_last,
  output logic overflow
);

  localparam int RW = $clog2(MAX_SYMS);
  localparam int LW = $clog2(MAX_SYMS + 1);
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(64);

  fsm_t state, state_nxt;

  logic [PM_W-1:0]    pm     [NSTATES];
  logic [PM_W-1:0]    pm_new [NSTATES];
  logic [NSTATES-1:0] dec;
  logic [NSTATES-1:0] surv_mem [MAX_SYMS];
  logic [MAX_SYMS-1:0] bit_buf;

  logic [LW-1:0] len;      // symbols stored in the current frame
  logic [LW-1:0] n_out;    // bits to emit for this frame
  logic [RW-1:0] row;      // traceback row
  logic [RW-1:0] out_idx;  // next buffer index to emit
  state_t        tb_state;
  state_t        start_state;

  logic sym_acc, frame_end, tb_done, out_acc, out_done, reinit;

  // ACS array: state g is reached from {g[5:0], x}, x = 0/1.
  for (genvar g = 0; g < NSTATES; g++) begin : g_acs
    localparam state_t S  = state_t'(g);
    localparam int     P0 = (2 * g) % NSTATES;
    logic [1:0] bm0, bm1;
    assign bm0 = hamming2(expected_sym(S, 1'b0), {n1, n2});
    assign bm1 = hamming2(expected_sym(S, 1'b1), {n1, n2});
    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm0   (pm[P0]),
      .pm1   (pm[P0 + 1]),
      .bm0   (bm0),
      .bm1   (bm1),
      .pm_new(pm_new[g]),
      .dec   (dec[g])
    );
  end

`ifdef ZERO_TAIL_EN
  assign n_out       = (len > LW'(K)) ? len - LW'(K) : '0;
  assign start_state = '0;
`else
  assign n_out = len;
  // Min over the metrics being written by the final symbol; strict '<'
  // keeps the lowest index on ties.
  logic [PM_W-1:0] best_pm;
  always_comb begin
    best_pm     = pm_new[0];
    start_state = '0;
    for (int i = 1; i < NSTATES; i++) begin
      if (pm_new[i] < best_pm) begin
        best_pm     = pm_new[i];
        start_state = state_t'(i);
      end
    end
  end
`endif

  assign sym_acc   = (state == RECV) && sym_valid;
  assign frame_end = sym_acc && (sym_last || (len == LW'(MAX_SYMS - 1)));
  assign tb_done   = (state == TRACE) && (row == '0);
  assign out_acc   = (state == OUT) && msg_ready;
  assign out_done  = out_acc && (LW'(out_idx) == n_out - LW'(1));
  assign reinit    = (tb_done && (n_out == '0)) || out_done;

  assign sym_ready = (state == RECV);
  assign msg_valid = (state == OUT);
  assign msg_out   = msg_valid & bit_buf[out_idx];
  assign msg_last  = msg_valid && (LW'(out_idx) == n_out - LW'(1));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= RECV;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RECV:    if (frame_end) state_nxt = TRACE;
      TRACE:   if (tb_done)   state_nxt = (n_out == '0) ? RECV : OUT;
      OUT:     if (out_done)  state_nxt = RECV;
      default: state_nxt = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NSTATES; i++) pm[i] <= (i == 0) ? '0 : PM_INIT;
      len      <= '0;
      row      <= '0;
      out_idx  <= '0;
      tb_state <= '0;
      bit_buf  <= '0;
      overflow <= 1'b0;
    end else begin
      if (sym_acc) begin
        for (int i = 0; i < NSTATES; i++) pm[i] <= pm_new[i];
        len      <= len + LW'(1);
        overflow <= 1'b0;
        if (frame_end) begin
          row      <= len[RW-1:0];
          tb_state <= start_state;
          if (!sym_last) overflow <= 1'b1;
        end
      end
      if (state == TRACE) begin
        bit_buf[row] <= tb_state[K-2];
        tb_state     <= {tb_state[K-3:0], surv_mem[row][tb_state]};
        row          <= row - RW'(1);
      end
      if (out_acc) out_idx <= out_idx + RW'(1);
      if (reinit) begin
        for (int i = 0; i < NSTATES; i++) pm[i] <= (i == 0) ? '0 : PM_INIT;
        len     <= '0;
        out_idx <= '0;
      end
    end
  end

  // Survivor memory needs no reset: rows are always written before traceback reads them.
  always_ff @(posedge clk) begin
    if (sym_acc) surv_mem[len[RW-1:0]] <= dec;
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder: impulse frames, random encoded frames
// with sparse bit errors, output back-pressure, overflow truncation, mid-frame reset.
// Expected bits come from the transmitted message; ZERO_TAIL_EN selects the tail rule.
module tb_viterbi_decoder;

  localparam int MAXS = 64;
`ifdef ZERO_TAIL_EN
  localparam int TAIL = 8;
`else
  localparam int TAIL = 0;
`endif

  logic clk = 1'b0;
  logic n_reset = 1'b1;
  logic sym_valid = 1'b0, n1 = 1'b0, n2 = 1'b0, sym_last = 1'b0, msg_ready = 1'b1;
  logic sym_ready, msg_out, msg_valid, msg_last, overflow;

  int checks = 0;
  int errors = 0;

  viterbi_decoder #(.MAX_SYMS(MAXS), .PM_W(8)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .sym_valid(sym_valid),
    .n1       (n1),
    .n2       (n2),
    .sym_last (sym_last),
    .sym_ready(sym_ready),
    .msg_out  (msg_out),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .msg_last (msg_last),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: shift each bit into an 8-bit register, emit generator parities.
  function automatic void encode(input bit msg[$], output logic [1:0] syms[$]);
    logic [7:0] r;
    r = '0;
    syms = {};
    foreach (msg[i]) begin
      r = {msg[i], r[7:1]};
      syms.push_back({^(r & 8'b11111001), ^(r & 8'b10100111)});
    end
  endfunction

  task automatic send_syms(input logic [1:0] syms[$], input bit mark_last);
    int guard;
    foreach (syms[i]) begin
      guard     = 0;
      sym_valid = 1'b1;
      {n1, n2}  = syms[i];
      sym_last  = mark_last && (i == syms.size() - 1);
      while (!sym_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) check_eq("sym_ready_timeout", 0, 1);
      @(negedge clk);
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
  endtask

  // Waits for the first bit (checking latency), then drains until msg_last.
  // bp_at >= 0 stalls msg_ready for 5 cycles once that many bits were taken.
  task automatic collect(input int exp_lat, input int bp_at, output bit got[$]);
    int lat, guard, stall;
    logic [2:0] held;
    bit done;
    got = {};
    lat = 0; guard = 0; stall = 0; done = 0; held = '0;
    msg_ready = 1'b1;
    while (!msg_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", lat, exp_lat);
    while (!done && guard < 400) begin
      guard++;
      if (bp_at >= 0 && got.size() == bp_at && stall < 5) begin
        if (stall == 0) held = {msg_valid, msg_out, msg_last};
        else check_eq("bp_hold", {msg_valid, msg_out, msg_last}, held);
        msg_ready = 1'b0;
        stall++;
      end else begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          got.push_back(msg_out);
          done = msg_last;
        end
      end
      @(negedge clk);
    end
    msg_ready = 1'b1;
    check_eq("valid_drop", msg_valid, 0);
  endtask

  task automatic compare_bits(input string tag, input bit got[$], input bit full[$], input int n);
    logic [63:0] gv, ev;
    gv = '0;
    ev = '0;
    for (int i = 0; i < n && i < 64; i++) ev[i] = full[i];
    foreach (got[i]) if (i < 64) gv[i] = got[i];
    check_eq({tag, "_count"}, got.size(), n);
    check_eq({tag, "_bits"}, gv, ev);
  endtask

  task automatic run_frame(input string tag, input logic [1:0] syms[$], input bit full[$],
                           input int bp_at);
    bit got[$];
    int l;
    l = syms.size();
    send_syms(syms, 1'b1);
    collect(l, bp_at, got);
    compare_bits(tag, got, full, (l > TAIL) ? l - TAIL : 0);
  endtask

  initial begin
    logic [1:0] imp[$];
    logic [1:0] imp_err[$];
    logic [1:0] syms[$];
    logic [1:0] tmp;
    bit imp_bits[$];
    bit msg[$];
    bit got[$];
    int p;

    imp = {2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00};
    imp_bits = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    #2 n_reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_sym_ready", sym_ready, 1);
    check_eq("rst_msg_valid", msg_valid, 0);
    check_eq("rst_msg_out", msg_out, 0);
    check_eq("rst_msg_last", msg_last, 0);
    check_eq("rst_overflow", overflow, 0);
    n_reset = 1'b1;
    @(negedge clk);

    // Impulse, clean and with one corrupted bit
    run_frame("impulse", imp, imp_bits, -1);
    check_eq("impulse_ovf", overflow, 0);
    imp_err = imp;
    imp_err[1] = 2'b00;
    run_frame("impulse_err", imp_err, imp_bits, -1);

    // Random 40-bit messages + 8 flush bits, 0..2 separated errors, one with back-pressure
    for (int it = 0; it < 3; it++) begin
      msg = {};
      for (int i = 0; i < 40; i++) msg.push_back(bit'($urandom_range(0, 1)));
      for (int i = 0; i < 8; i++) msg.push_back(1'b0);
      encode(msg, syms);
      if (it >= 1) begin
        p = $urandom_range(3, 12);
        tmp = syms[p];
        tmp[$urandom_range(0, 1)] ^= 1'b1;
        syms[p] = tmp;
      end
      if (it >= 2) begin
        p = $urandom_range(26, 36);
        tmp = syms[p];
        tmp[$urandom_range(0, 1)] ^= 1'b1;
        syms[p] = tmp;
      end
      run_frame("random", syms, msg, (it == 2) ? 17 : -1);
    end

    // Overflow: 64 accepted symbols without sym_last, then 6 refused attempts
    msg = {};
    for (int i = 0; i < 56; i++) msg.push_back(bit'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) msg.push_back(1'b0);
    encode(msg, syms);
    send_syms(syms, 1'b0);
    check_eq("ovf_flag", overflow, 1);
    for (int i = 0; i < 6; i++) begin
      sym_valid = 1'b1;
      {n1, n2} = 2'($urandom_range(0, 3));
      check_eq("ovf_ready_low", sym_ready, 0);
      @(negedge clk);
    end
    sym_valid = 1'b0;
    collect(MAXS - 6, -1, got);
    compare_bits("overflow", got, msg, MAXS - TAIL);
    check_eq("ovf_sticky", overflow, 1);
    run_frame("after_ovf", imp, imp_bits, -1);
    check_eq("ovf_clear", overflow, 0);

    // Reset in the middle of a frame
    syms = {};
    for (int i = 0; i < 10; i++) syms.push_back(2'($urandom_range(0, 3)));
    send_syms(syms, 1'b0);
    n_reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_sym_ready", sym_ready, 1);
    check_eq("midrst_msg_valid", msg_valid, 0);
    n_reset = 1'b1;
    @(negedge clk);
    run_frame("post_reset", imp, imp_bits, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/viterbi_decoder.md
# viterbi_decoder

Hard-decision Viterbi decoder for the team's rate-1/2, constraint-length-8 convolutional code with generators G1 = 8'b11111001 and G2 = 8'b10100111. It sits on the receive side opposite `convolutional_encoder` and accepts one received symbol pair (n1, n2) per handshake. At frame end it traces back through the stored survivors and streams out the decoded message bits in transmit order.

## Interface
- MAX_SYMS, 64: maximum symbols per frame, including flush symbols; sets survivor-memory depth.
- PM_W, 8: path-metric width in bits.
- clk  in  1  clock; all state changes on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- sym_valid  in  1  received symbol pair present.
- n1, n2  in  1 each  received hard bits, G1 and G2 parity respectively.
- sym_last  in  1  marks the final symbol of the frame.
- sym_ready  out  1  decoder accepts a symbol; high only in RECV.
- msg_out  out  1  decoded message bit.
- msg_valid  out  1  msg_out is valid.
- msg_ready  in  1  downstream accepts msg_out.
- msg_last  out  1  marks the final decoded bit of the frame.
- overflow  out  1  sticky flag: the frame was truncated at MAX_SYMS.

## Operation
**Trellis model**
- Encoder register after a shift: R = {b_k, b_k-1, …, b_k-7}.
- Transmitted symbol: n1 = ^(G1 & R), n2 = ^(G2 & R).
- Decoder state S_k = {b_k … b_k-6}, 7 bits, 128 states.
- Predecessors of S are {S[5:0], x} for x in {0, 1}. Decision bit = x.
- Traceback step: decoded bit = S[6], previous state = {S[5:0], d}.

**Metrics**
- Branch metric = Hamming distance (0..2) between the received pair and the expected pair.
- Path metric update: PM' = min over both predecessors of (PM + BM), using saturating add at 2^PM_W − 1.
- Tie rule: select x = 0.
- Frame-start metric init: state 0 = 0, all other states = 64.

**State machine**
- RECV:
  - sym_ready = 1.
  - Each accepted symbol updates all 128 metrics in parallel and writes the 128 decision bits to survivor row L, then L++.
  - Transition to TRACE when the accepted symbol has sym_last = 1, or when L reaches MAX_SYMS. In the MAX_SYMS case, set overflow.
- TRACE:
  - One traceback step per cycle, rows L−1 down to 0.
  - Each decoded bit is written to the bit buffer at its row index.
- OUT:
  - Emit buffer indices 0..N−1 under a valid/ready handshake.
  - msg_last accompanies index N−1.
  - After the final transfer: reinit metrics, set L = 0, go to RECV.
  - If N = 0, go straight to RECV without asserting msg_valid.
- overflow clears when the first symbol of the next frame is accepted.

**Handshakes and reset**
- msg_out, msg_valid and msg_last hold steady while msg_valid = 1 and msg_ready = 0.
- Reset at any time, mid-frame included: return to RECV, reinit metrics, set L = 0, discard any partial output.

## Timing
- Reset values: sym_ready = 1, msg_valid = 0, msg_out = 0, msg_last = 0, overflow = 0.
- Symbol throughput is one per cycle in RECV; ACS is single-cycle combinational into the metric registers.
- The TRACE cycle count equals L. The traceback start state is registered on the cycle that leaves RECV.
- The first msg_valid rises on the cycle after the last TRACE step. Output rate is one bit per cycle while msg_ready = 1.
- Frame latency from the sym_last handshake to the first msg_valid is L + 1 cycles.

## Configuration
- ZERO_TAIL_EN defined:
  - The frame is N message symbols followed by 8 flush symbols; the transmitter shifts until `zeroed` drops.
  - Traceback starts from state 0.
  - The final 8 decoded bits are dropped, so N = L − 8 (clamped at 0).
- ZERO_TAIL_EN undefined:
  - Traceback starts from the minimum-metric state, lowest index on ties.
  - All bits are output, so N = L.

## Structure
- Package `viterbi_pkg`:
  - K = 8, NSTATES = 128, GEN1, GEN2.
  - state_t (logic [6:0]).
  - FSM enum {RECV, TRACE, OUT}.
  - Function expected_sym(state, bit) returning {n1, n2}.
- Sub-module `viterbi_acs`: one add-compare-select cell, instantiated NSTATES times by a generate loop.
  - Inputs: two predecessor metrics, two branch metrics.
  - Outputs: new metric, decision bit.

## Test plan
- Impulse, ZERO_TAIL_EN set:
  - Stimulus: symbols 11, 10, 11, 10, 10, 01, 01, 11, 00 with sym_last on the ninth.
  - Required: exactly one output bit, msg_out = 1 with msg_last; overflow = 0.
- Impulse with one corrupted bit (second symbol sent as 00):
  - Required: still a single output bit, 1.
- Random 40-bit message encoded by a golden model, plus 8 flush symbols, with up to 2 well-separated bit errors:
  - Required: all 40 bits match.
- Back-pressure:
  - Stimulus: hold msg_ready = 0 for 5 cycles mid-OUT.
  - Required: msg_out and msg_valid stable throughout; no bit lost or duplicated.
- Overflow:
  - Stimulus: 70 symbols with no sym_last.
  - Required: sym_ready drops after the 64th symbol; overflow = 1; 56 bits emitted.
- Reset mid-frame:
  - Stimulus: assert n_reset low after 10 symbols, then send the impulse frame.
  - Required: sym_ready = 1 and msg_valid = 0 during reset; after reset the impulse decodes correctly.
